// File: rtl/apb_slave_mem_wait.sv
// ---------------------------------------------------------------------------
// apb_slave_mem_wait
// Parametrised APB scratch RAM / register-file target with programmable
// wait-state insertion, byte-address decode and alignment/range checking.
//
// Optional feature macro: APB_PSTRB_EN
//   defined   -> PSTRB port present, per-byte-lane write enables
//   undefined -> no PSTRB port, every successful write updates all lanes
//
// Ports
//   PCLK     in   clock, all logic on rising edge
//   PRESETn  in   synchronous active-low reset
//   PADDR    in   byte address [ADDR_WIDTH]
//   PSELx    in   slave select
//   PENABLE  in   access-phase strobe
//   PWRITE   in   1 = write, 0 = read
//   PWDATA   in   write data [DATA_WIDTH]
//   PSTRB    in   byte-lane strobes [DATA_WIDTH/8] (APB_PSTRB_EN only)
//   PRDATA   out  read data, registered
//   PREADY   out  transfer complete, registered
//   PSLVERR  out  transfer error, registered, meaningful while PREADY=1
//
// Parameters
//   ADDR_WIDTH   PADDR width
//   DATA_WIDTH   data width, multiple of 8 in 8..64
//   MEM_DEPTH    number of words, >= 1, any value
//   WAIT_CYCLES  PREADY-low cycles per access phase, 0..15
// ---------------------------------------------------------------------------
module apb_slave_mem_wait #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSELx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned LSB    = (NBYTES > 1) ? $clog2(NBYTES) : 0;
  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CMP_W  = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

  // Low address bits that must be zero for a word-aligned access (none for 8-bit data).
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    err_q, err_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic                    mem_we;
  logic [NBYTES-1:0]       mem_be;

  // Address decode of the current bus address (used at the setup edge).
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic                    misalign;
  logic                    out_of_range;
  logic                    dec_err;
  logic [IDX_W-1:0]        dec_idx;

  assign word_addr    = PADDR >> LSB;
  assign misalign     = |(PADDR & ALIGN_MASK);
  assign out_of_range = CMP_W'(word_addr) >= CMP_W'(MEM_DEPTH);
  assign dec_err      = misalign | out_of_range;
  assign dec_idx      = IDX_W'(word_addr);

  // Wait counter increment and terminal-count detect.
  logic [CNT_W:0]          cnt_inc;
  logic                    wait_hit;

  assign cnt_inc  = (CNT_W + 1)'(cnt_q) + (CNT_W + 1)'(1);
  assign wait_hit = (cnt_inc == (CNT_W + 1)'(WAIT_CYCLES));

  // Byte-lane enables for a completing write.
  logic [NBYTES-1:0]       lane_en;

`ifdef APB_PSTRB_EN
  assign lane_en = PSTRB;
`else
  assign lane_en = '1;
`endif

  logic                    access_ok;
  assign access_ok = PSELx & PENABLE;

  // State register.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (PSELx && !PENABLE) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Leave on completion, or on a protocol violation (select/enable dropped).
        if (!access_ok || pready_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-value logic.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    write_d   = write_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    mem_we    = 1'b0;
    mem_be    = '0;

    case (state_q)
      S_IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        if (PSELx && !PENABLE) begin
          idx_d    = dec_idx;
          err_d    = dec_err;
          write_d  = PWRITE;
          cnt_d    = '0;
          pready_d = (WAIT_CYCLES == 0);
          // With no wait states the response is launched from the setup edge.
          if (WAIT_CYCLES == 0) begin
            pslverr_d = dec_err;
            if (!PWRITE) begin
              prdata_d = dec_err ? '0 : mem_q[dec_idx];
            end
          end
        end
      end

      S_ACCESS: begin
        if (!access_ok) begin
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (!pready_q) begin
          cnt_d = cnt_inc[CNT_W-1:0];
          if (wait_hit) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            if (!write_q) begin
              prdata_d = err_q ? '0 : mem_q[idx_q];
            end
          end
        end else begin
          // Completing edge: commit the write with data sampled now.
          mem_we    = write_q & ~err_q;
          mem_be    = lane_en;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end
      end

      default: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      write_q   <= write_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Storage array; contents survive reset, a write coinciding with reset is dropped.
  always_ff @(posedge PCLK) begin
    if (PRESETn && mem_we) begin
      for (int b = 0; b < int'(NBYTES); b++) begin
        if (mem_be[b]) begin
          mem_q[idx_q][8*b +: 8] <= PWDATA[8*b +: 8];
        end
      end
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem_wait.sv
// Bench for apb_slave_mem_wait: three instances (WAIT_CYCLES 2, 0, 3) on a
// shared APB bus with per-instance select. The driver queues the expected
// response of every transfer; a negedge monitor pops and compares it when the
// selected slave completes, and also checks reset outputs and stray PREADY.
module tb_apb_slave_mem_wait;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int TMO = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          rst_q;
  logic [AW-1:0] paddr;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          psel    [3];
  logic [DW-1:0] prdata  [3];
  logic          pready  [3];
  logic          pslverr [3];
`ifdef APB_PSTRB_EN
  logic [DW/8-1:0] pstrb;
  logic [DW/8-1:0] strb_next;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_mem_wait #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_DEPTH  (256),
      .WAIT_CYCLES((g == 0) ? 2 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .PCLK   (clk),
      .PRESETn(rst_n),
      .PADDR  (paddr),
      .PSELx  (psel[g]),
      .PENABLE(penable),
      .PWRITE (pwrite),
      .PWDATA (pwdata),
`ifdef APB_PSTRB_EN
      .PSTRB  (pstrb),
`endif
      .PRDATA (prdata[g]),
      .PREADY (pready[g]),
      .PSLVERR(pslverr[g])
    );
  end

  typedef struct {
    logic          is_read;
    logic [DW-1:0] rdata;
    logic          err;
    int            waits;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;
  int wcnt [3];
  bit drv_tmo  = 1'b0;
  bit tmo_cnt  = 1'b0;
  bit done     = 1'b0;
  bit mon_done = 1'b0;

  always @(posedge clk) rst_q <= rst_n;

  function automatic int waits_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic push_exp(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic bus_clear();
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    penable = 1'b0;
  endtask

  task automatic setup(input int d, input logic [AW-1:0] a, input logic wr,
                       input logic [DW-1:0] wd);
    @(posedge clk); #1;
    bus_clear();
    psel[d] = 1'b1;
    paddr   = a;
    pwrite  = wr;
    pwdata  = wd;
`ifdef APB_PSTRB_EN
    pstrb   = strb_next;
`endif
  endtask

  // Full transfer; returns at the negedge where PREADY is seen so the next
  // call's setup lands right after the completing edge.
  task automatic xfer(input int d, input logic [AW-1:0] a, input logic wr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rexp,
                      input logic eexp);
    exp_t e;
    int   n;
    e.is_read = !wr;
    e.rdata   = rexp;
    e.err     = eexp;
    e.waits   = waits_of(d);
    push_exp(d, e);
    setup(d, a, wr, wd);
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pready[d] !== 1'b1 && n < TMO);
    if (pready[d] !== 1'b1) drv_tmo = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus_clear();
    end
  endtask

  // Select dropped in the second access cycle.
  task automatic abort_write(input int d, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    setup(d, a, 1'b1, wd);
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel[d] = 1'b0;
  endtask

  // Reset asserted during a wait state of a write.
  task automatic reset_write(input int d, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    setup(d, a, 1'b1, wd);
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int i = 0; i < 3; i++) begin
      if (rst_q === 1'b0) begin
        checks++;
        if (pready[i] !== 1'b0 || pslverr[i] !== 1'b0 || prdata[i] !== '0) begin
          errors++;
          $display("FAIL reset_out dut%0d: pready=%b pslverr=%b prdata=%h, required 0 0 00000000",
                   i, pready[i], pslverr[i], prdata[i]);
        end
        wcnt[i] = 0;
      end else if (rst_n !== 1'b1) begin
        wcnt[i] = 0;
      end else if (psel[i] === 1'b1 && penable === 1'b1) begin
        if (pready[i] !== 1'b1) begin
          wcnt[i]++;
        end else begin
          have = 1'b0;
          case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
          endcase
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL unexpected_resp dut%0d: pready=1 with no transfer expected, required none", i);
          end else if (pslverr[i] !== e.err || wcnt[i] != e.waits ||
                       (e.is_read && prdata[i] !== e.rdata)) begin
            errors++;
            $display("FAIL resp dut%0d addr=%h: pslverr=%b waits=%0d prdata=%h, required pslverr=%b waits=%0d prdata=%h%s",
                     i, paddr, pslverr[i], wcnt[i], prdata[i], e.err, e.waits, e.rdata,
                     e.is_read ? "" : " (write, data not compared)");
          end
          wcnt[i] = 0;
        end
      end else begin
        wcnt[i] = 0;
        checks++;
        if (pready[i] !== 1'b0 || pslverr[i] !== 1'b0) begin
          errors++;
          $display("FAIL stray_ready dut%0d: pready=%b pslverr=%b outside access, required 0 0",
                   i, pready[i], pslverr[i]);
        end
      end
    end
    if (drv_tmo && !tmo_cnt) begin
      tmo_cnt = 1'b1;
      checks++;
      errors++;
      $display("FAIL timeout: PREADY not seen within %0d cycles, required PREADY=1", TMO);
    end
    if (done && !mon_done) begin
      checks++;
      if (q0.size() + q1.size() + q2.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_empty: %0d responses outstanding, required 0",
                 q0.size() + q1.size() + q2.size());
      end
      mon_done = 1'b1;
    end
  end

  initial begin
    rst_n   = 1'b0;
    paddr   = '0;
    pwrite  = 1'b0;
    pwdata  = '0;
    bus_clear();
    for (int i = 0; i < 3; i++) wcnt[i] = 0;
`ifdef APB_PSTRB_EN
    pstrb     = '1;
    strb_next = '1;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Write then read with two wait states.
    xfer(0, 32'h28, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
    xfer(0, 32'h28, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

    // Zero wait states, back-to-back.
    xfer(1, 32'h0, 1'b1, 32'h11, 32'h0, 1'b0);
    xfer(1, 32'h4, 1'b1, 32'h22, 32'h0, 1'b0);
    xfer(1, 32'h0, 1'b0, 32'h0, 32'h11, 1'b0);
    xfer(1, 32'h4, 1'b0, 32'h0, 32'h22, 1'b0);
    xfer(1, 32'h404, 1'b0, 32'h0, 32'h0, 1'b1);
    xfer(1, 32'h4, 1'b0, 32'h0, 32'h22, 1'b0);

    // Range and alignment errors, top word boundary.
    xfer(0, 32'h0, 1'b1, 32'h13572468, 32'h0, 1'b0);
    xfer(0, 32'h3FC, 1'b1, 32'h0F0F0F0F, 32'h0, 1'b0);
    xfer(0, 32'h3FC, 1'b0, 32'h0, 32'h0F0F0F0F, 1'b0);
    xfer(0, 32'h404, 1'b0, 32'h0, 32'h0, 1'b1);
    xfer(0, 32'h400, 1'b0, 32'h0, 32'h0, 1'b1);
    xfer(0, 32'h402, 1'b1, 32'hBAD0BAD0, 32'h0, 1'b1);
    xfer(0, 32'h1, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1);
    xfer(0, 32'h2, 1'b0, 32'h0, 32'h0, 1'b1);
    xfer(0, 32'h0, 1'b0, 32'h0, 32'h13572468, 1'b0);

    // Abort by dropping select (three wait states).
    xfer(2, 32'h8, 1'b1, 32'hA5A5A5A5, 32'h0, 1'b0);
    abort_write(2, 32'h8, 32'h5A5A5A5A);
    idle(3);
    xfer(2, 32'h8, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0);

    // Reset during a write's wait state.
    xfer(0, 32'h30, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0);
    reset_write(0, 32'h30, 32'h12345678);
    idle(1);
    xfer(0, 32'h30, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
    xfer(0, 32'h34, 1'b1, 32'h600DF00D, 32'h0, 1'b0);
    xfer(0, 32'h34, 1'b0, 32'h0, 32'h600DF00D, 1'b0);

`ifdef APB_PSTRB_EN
    // Byte-lane strobes.
    strb_next = 4'hF;
    xfer(1, 32'h10, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0);
    strb_next = 4'b0101;
    xfer(1, 32'h10, 1'b1, 32'h00AB00CD, 32'h0, 1'b0);
    strb_next = 4'b0000;
    xfer(1, 32'h10, 1'b1, 32'h12345678, 32'h0, 1'b0);
    strb_next = 4'hF;
    xfer(1, 32'h10, 1'b0, 32'h0, 32'hFFABFFCD, 1'b0);
`endif

    idle(3);
    done = 1'b1;
    for (int k = 0; k < 10 && !mon_done; k++) @(posedge clk);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
